// File: rtl/n101_icache_pkg.sv
// Shared constants for the n101 I-cache tag-RAM controller: default geometry,
// FSM encoding, tag field layout and the parity-width switch (N101_ICACHE_TRAM_PARITY_EN).
package n101_icache_pkg;

    localparam int AW_DEF  = 6;
    localparam int TW_DEF  = 22;
    localparam int DP_DEF  = 2 ** AW_DEF;

    // Tag entry layout: {valid, tag}; valid is the MSB.
    localparam int VLD_BIT = TW_DEF - 1;

`ifdef N101_ICACHE_TRAM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    localparam logic [0:0] SWEEP = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

endpackage

// File: rtl/n101_icache_tram_par.sv
// Even-parity generate/check for one tag-RAM way.
// Ports: wr_data in (TW) -> wr_word out {parity, data}; rd_word in (TW+1) -> rd_err out.
module n101_icache_tram_par #(
    parameter int TW = 22
) (
    input  logic [TW-1:0] wr_data,
    output logic [TW:0]   wr_word,
    input  logic [TW:0]   rd_word,
    output logic          rd_err
);

    assign wr_word = {^wr_data, wr_data};
    // A clean word has even parity over all TW+1 bits.
    assign rd_err  = ^rd_word;

endmodule

// File: rtl/n101_icache_tram_ctrl.sv
// Tag-RAM port controller for the n101 I-cache: post-reset / fence.i sweep,
// update-over-lookup arbitration, lookup response one cycle after acceptance.
// Ports: clk, rst (async, active-high); inv_req/inv_busy; lkp_valid/ready/idx;
//        rsp_valid, rsp_tag0/1; upd_valid/ready/way/idx/tag;
//        tag0/1 cs, we, addr, wdata (out), rdata (in); perr.
// Option: N101_ICACHE_TRAM_PARITY_EN adds a parity bit per RAM word and drives perr.
module n101_icache_tram_ctrl
    import n101_icache_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int TW   = TW_DEF,
    parameter int WAYS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inv_req,
    output logic                inv_busy,
    input  logic                lkp_valid,
    output logic                lkp_ready,
    input  logic [AW-1:0]       lkp_idx,
    output logic                rsp_valid,
    output logic [TW-1:0]       rsp_tag0,
    output logic [TW-1:0]       rsp_tag1,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic                upd_way,
    input  logic [AW-1:0]       upd_idx,
    input  logic [TW-1:0]       upd_tag,
    output logic                tag0_cs,
    output logic                tag0_we,
    output logic [AW-1:0]       tag0_addr,
    output logic [TW+PAR_W-1:0] tag0_wdata,
    input  logic [TW+PAR_W-1:0] tag0_rdata,
    output logic                tag1_cs,
    output logic                tag1_we,
    output logic [AW-1:0]       tag1_addr,
    output logic [TW+PAR_W-1:0] tag1_wdata,
    input  logic [TW+PAR_W-1:0] tag1_rdata,
    output logic                perr
);

    localparam bit TWO = (WAYS == 2);

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic          sweep;
    logic          run;
    logic          lkp_go;
    logic          sel1;
    logic          cs0, we0, cs1, we1;
    logic [AW-1:0] addr;
    logic [TW-1:0] wr_data;

    assign sweep     = (state == SWEEP);
    assign run       = (state == RUN);
    assign inv_busy  = sweep;
    assign upd_ready = run;
    assign lkp_ready = run && !upd_valid && !inv_req;
    assign lkp_go    = lkp_valid && lkp_ready;
    assign sel1      = TWO && upd_way;

    // Sweep strobes are held off while rst is high so the RAM sees no
    // writes until reset is released.
    always_comb begin
        cs0     = 1'b0;
        we0     = 1'b0;
        cs1     = 1'b0;
        we1     = 1'b0;
        addr    = '0;
        wr_data = '0;
        if (sweep && !rst) begin
            cs0  = 1'b1;
            we0  = 1'b1;
            cs1  = 1'b1;
            we1  = 1'b1;
            addr = cnt;
        end else if (run && upd_valid) begin
            cs0     = !sel1;
            we0     = !sel1;
            cs1     = sel1;
            we1     = sel1;
            addr    = upd_idx;
            wr_data = upd_tag;
        end else if (lkp_go) begin
            cs0  = 1'b1;
            cs1  = 1'b1;
            addr = lkp_idx;
        end
    end

    assign tag0_cs   = cs0;
    assign tag0_we   = we0;
    assign tag0_addr = addr;
    assign tag1_cs   = TWO && cs1;
    assign tag1_we   = TWO && we1;
    assign tag1_addr = TWO ? addr : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SWEEP;
            cnt       <= '0;
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= lkp_go;
            if (inv_req) begin
                state <= SWEEP;
                cnt   <= '0;
            end else if (sweep) begin
                if (&cnt) begin
                    state <= RUN;
                end
                cnt <= cnt + AW'(1);
            end
        end
    end

`ifdef N101_ICACHE_TRAM_PARITY_EN
    logic [TW:0] wd0, wd1;
    logic        err0, err1;

    n101_icache_tram_par #(.TW(TW)) u_par0 (
        .wr_data (wr_data),
        .wr_word (wd0),
        .rd_word (tag0_rdata),
        .rd_err  (err0)
    );

    n101_icache_tram_par #(.TW(TW)) u_par1 (
        .wr_data (wr_data),
        .wr_word (wd1),
        .rd_word (tag1_rdata),
        .rd_err  (err1)
    );

    assign tag0_wdata = wd0;
    assign tag1_wdata = TWO ? wd1 : '0;
    assign rsp_tag0   = tag0_rdata[TW-1:0];
    assign rsp_tag1   = TWO ? tag1_rdata[TW-1:0] : '0;
    assign perr       = rsp_valid && (err0 || (TWO && err1));
`else
    assign tag0_wdata = wr_data;
    assign tag1_wdata = TWO ? wr_data : '0;
    assign rsp_tag0   = tag0_rdata;
    assign rsp_tag1   = TWO ? tag1_rdata : '0;
    assign perr       = 1'b0;
`endif

endmodule

// File: tb/tb_n101_icache_tram_ctrl.sv
// Self-checking bench for n101_icache_tram_ctrl with a behavioural tag RAM,
// a reference tag array and a response scoreboard queue.
module tb_n101_icache_tram_ctrl;
    import n101_icache_pkg::*;

    localparam int AW  = AW_DEF;
    localparam int TW  = TW_DEF;
    localparam int DP  = DP_DEF;
    localparam int TWR = TW + PAR_W;

    logic           clk, rst, inv_req, inv_busy;
    logic           lkp_valid, lkp_ready, rsp_valid, perr;
    logic [AW-1:0]  lkp_idx, upd_idx;
    logic [TW-1:0]  rsp_tag0, rsp_tag1, upd_tag;
    logic           upd_valid, upd_ready, upd_way;
    logic           tag0_cs, tag0_we, tag1_cs, tag1_we;
    logic [AW-1:0]  tag0_addr, tag1_addr;
    logic [TWR-1:0] tag0_wdata, tag1_wdata, tag0_rdata, tag1_rdata;

    logic [TWR-1:0] mem0 [DP];
    logic [TWR-1:0] mem1 [DP];
    logic [TWR-1:0] rd0, rd1, flip0;
    logic [TW-1:0]  ref0 [DP];
    logic [TW-1:0]  ref1 [DP];
    logic [2*TW-1:0] sbq [$];
    logic [2*TW-1:0] exp_rsp;

    int checks = 0;
    int errors = 0;

    n101_icache_tram_ctrl #(.AW(AW), .TW(TW), .WAYS(2)) dut (
        .clk(clk), .rst(rst), .inv_req(inv_req), .inv_busy(inv_busy),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_idx(lkp_idx),
        .rsp_valid(rsp_valid), .rsp_tag0(rsp_tag0), .rsp_tag1(rsp_tag1),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_way(upd_way),
        .upd_idx(upd_idx), .upd_tag(upd_tag),
        .tag0_cs(tag0_cs), .tag0_we(tag0_we), .tag0_addr(tag0_addr),
        .tag0_wdata(tag0_wdata), .tag0_rdata(tag0_rdata),
        .tag1_cs(tag1_cs), .tag1_we(tag1_we), .tag1_addr(tag1_addr),
        .tag1_wdata(tag1_wdata), .tag1_rdata(tag1_rdata),
        .perr(perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port tag RAM per way.
    always @(posedge clk) begin
        if (tag0_cs && tag0_we) mem0[tag0_addr] <= tag0_wdata;
        else if (tag0_cs) rd0 <= mem0[tag0_addr];
        if (tag1_cs && tag1_we) mem1[tag1_addr] <= tag1_wdata;
        else if (tag1_cs) rd1 <= mem1[tag1_addr];
    end
    assign tag0_rdata = rd0 ^ flip0;
    assign tag1_rdata = rd1;

    function automatic logic [TWR-1:0] enc(input logic [TW-1:0] d);
`ifdef N101_ICACHE_TRAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    task automatic clear_ref();
        for (int i = 0; i < DP; i++) begin
            ref0[i] = '0;
            ref1[i] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered just after a posedge with the sweep at cnt=0.
    task automatic run_sweep(input string name);
        int n;
        int bad;
        n = 0;
        bad = -1;
        @(negedge clk);
        while (inv_busy === 1'b1 && n < 200) begin
            if (!(tag0_cs === 1'b1 && tag0_we === 1'b1 && tag1_cs === 1'b1 &&
                  tag1_we === 1'b1 && tag0_addr === AW'(n) &&
                  tag1_addr === AW'(n) && tag0_wdata === '0 &&
                  tag1_wdata === '0 && lkp_ready === 1'b0 &&
                  upd_ready === 1'b0 && rsp_valid === 1'b0) && bad < 0)
                bad = n;
            n++;
            @(negedge clk);
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_pattern: bad strobes at sweep cycle %0d addr=%0d, required addr=%0d cs/we=1 wdata=0",
                     name, bad, tag0_addr, bad);
        end
        checks++;
        if (n != DP) begin
            errors++;
            $display("FAIL %s_len: sweep lasted %0d cycles, required %0d", name, n, DP);
        end
        checks++;
        if (inv_busy !== 1'b0 || upd_ready !== 1'b1 || lkp_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_run: inv_busy=%b upd_ready=%b lkp_ready=%b, required 0 1 1",
                     name, inv_busy, upd_ready, lkp_ready);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lkp_valid = 1'b1;
        upd_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({inv_busy, lkp_ready, upd_ready, rsp_valid, perr,
             tag0_cs, tag0_we, tag1_cs, tag1_we} !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset: busy,lr,ur,rv,perr,cs0,we0,cs1,we1=%b, required 100000000",
                     {inv_busy, lkp_ready, upd_ready, rsp_valid, perr,
                      tag0_cs, tag0_we, tag1_cs, tag1_we});
        end
        lkp_valid = 1'b0;
        upd_valid = 1'b0;
        clear_ref();
    endtask

    task automatic test_sweep();
        tick();
        rst = 1'b0;
        run_sweep("init_sweep");
    endtask

    task automatic test_upd_lookup();
        upd_valid = 1'b1;
        upd_way = 1'b1;
        upd_idx = 6'd5;
        upd_tag = 22'h200ABC;
        @(negedge clk);
        checks++;
        if ({tag1_cs, tag1_we, tag0_cs, upd_ready} !== 4'b1101 ||
            tag1_addr !== 6'd5 || tag1_wdata !== enc(22'h200ABC)) begin
            errors++;
            $display("FAIL upd_way1: cs1,we1,cs0,ur=%b addr=%0d wdata=%h, required 1101 5 %h",
                     {tag1_cs, tag1_we, tag0_cs, upd_ready}, tag1_addr, tag1_wdata,
                     enc(22'h200ABC));
        end
        ref1[5] = 22'h200ABC;
        tick();
        upd_valid = 1'b0;
        lkp_valid = 1'b1;
        lkp_idx = 6'd5;
        @(negedge clk);
        checks++;
        if ({lkp_ready, tag0_cs, tag1_cs, tag0_we, tag1_we} !== 5'b11100 ||
            tag0_addr !== 6'd5) begin
            errors++;
            $display("FAIL lkp_issue: lr,cs0,cs1,we0,we1=%b addr=%0d, required 11100 5",
                     {lkp_ready, tag0_cs, tag1_cs, tag0_we, tag1_we}, tag0_addr);
        end
        sbq.push_back({ref0[5], ref1[5]});
        tick();
        lkp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
            errors++;
            $display("FAIL lkp_rsp_valid: rsp_valid=%b, required 1", rsp_valid);
        end else begin
            exp_rsp = sbq.pop_front();
            checks++;
            if ({rsp_tag0, rsp_tag1} !== exp_rsp || perr !== 1'b0) begin
                errors++;
                $display("FAIL lkp_rsp_data: tag0=%h tag1=%h perr=%b, required %h %h 0",
                         rsp_tag0, rsp_tag1, perr, exp_rsp[2*TW-1:TW], exp_rsp[TW-1:0]);
            end
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pulse: rsp_valid=%b, required 0", rsp_valid);
        end
        tick();
    endtask

    task automatic test_collision();
        upd_valid = 1'b1;
        upd_way = 1'b0;
        upd_idx = 6'd9;
        upd_tag = 22'h3F0F0F;
        lkp_valid = 1'b1;
        lkp_idx = 6'd9;
        @(negedge clk);
        checks++;
        if ({lkp_ready, tag0_cs, tag0_we, tag1_cs} !== 4'b0110 || tag0_addr !== 6'd9) begin
            errors++;
            $display("FAIL collide_upd: lr,cs0,we0,cs1=%b addr=%0d, required 0110 9",
                     {lkp_ready, tag0_cs, tag0_we, tag1_cs}, tag0_addr);
        end
        ref0[9] = 22'h3F0F0F;
        tick();
        upd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({lkp_ready, tag0_cs, tag0_we} !== 3'b110) begin
            errors++;
            $display("FAIL collide_lkp: lr,cs0,we0=%b, required 110",
                     {lkp_ready, tag0_cs, tag0_we});
        end
        sbq.push_back({ref0[9], ref1[9]});
        tick();
        lkp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
            errors++;
            $display("FAIL collide_rsp_valid: rsp_valid=%b, required 1", rsp_valid);
        end else begin
            exp_rsp = sbq.pop_front();
            checks++;
            if ({rsp_tag0, rsp_tag1} !== exp_rsp) begin
                errors++;
                $display("FAIL collide_rsp_data: tag0=%h tag1=%h, required %h %h",
                         rsp_tag0, rsp_tag1, exp_rsp[2*TW-1:TW], exp_rsp[TW-1:0]);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] idx [8];
        logic [TW-1:0] t;
        for (int j = 0; j < 8; j++) begin
            idx[j] = AW'($urandom_range(16, DP - 1));
            t = TW'($urandom);
            t[VLD_BIT] = 1'b1;
            upd_valid = 1'b1;
            upd_way = j[0];
            upd_idx = idx[j];
            upd_tag = t;
            if (j[0]) ref1[idx[j]] = t;
            else ref0[idx[j]] = t;
            tick();
        end
        upd_valid = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            lkp_valid = (i < 8);
            lkp_idx = idx[i % 8];
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_rsp_valid[%0d]: rsp_valid=%b, required 1", i, rsp_valid);
                end else begin
                    exp_rsp = sbq.pop_front();
                    checks++;
                    if ({rsp_tag0, rsp_tag1} !== exp_rsp) begin
                        errors++;
                        $display("FAIL b2b_rsp_data[%0d]: tag0=%h tag1=%h, required %h %h",
                                 i, rsp_tag0, rsp_tag1, exp_rsp[2*TW-1:TW], exp_rsp[TW-1:0]);
                    end
                end
            end
            if (i < 8) begin
                checks++;
                if (lkp_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: lkp_ready=%b, required 1", i, lkp_ready);
                end
                sbq.push_back({ref0[idx[i]], ref1[idx[i]]});
            end
            tick();
        end
    endtask

    task automatic test_inv_mid_sweep();
        lkp_valid = 1'b1;
        lkp_idx = 6'd5;
        inv_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({lkp_ready, tag0_cs, tag1_cs, inv_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL inv_run: lr,cs0,cs1,busy=%b, required 0000",
                     {lkp_ready, tag0_cs, tag1_cs, inv_busy});
        end
        clear_ref();
        tick();
        inv_req = 1'b0;
        for (int c = 0; c <= 30; c++) begin
            if (c == 30) inv_req = 1'b1;
            @(negedge clk);
            checks++;
            if (tag0_addr !== AW'(c) || tag0_we !== 1'b1 || lkp_ready !== 1'b0 ||
                rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL inv_pre[%0d]: addr=%0d we=%b lr=%b rv=%b, required %0d 1 0 0",
                         c, tag0_addr, tag0_we, lkp_ready, rsp_valid, c);
            end
            tick();
        end
        inv_req = 1'b0;
        run_sweep("inv_restart");
        sbq.push_back({ref0[5], ref1[5]});
        lkp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
            errors++;
            $display("FAIL inv_rsp_valid: rsp_valid=%b, required 1", rsp_valid);
        end else begin
            exp_rsp = sbq.pop_front();
            checks++;
            if ({rsp_tag0, rsp_tag1} !== exp_rsp) begin
                errors++;
                $display("FAIL inv_cleared: tag0=%h tag1=%h, required %h %h",
                         rsp_tag0, rsp_tag1, exp_rsp[2*TW-1:TW], exp_rsp[TW-1:0]);
            end
        end
        tick();
    endtask

    task automatic test_rst_mid_lookup();
        upd_valid = 1'b1;
        upd_way = 1'b0;
        upd_idx = 6'd12;
        upd_tag = 22'h2ABCDE;
        ref0[12] = 22'h2ABCDE;
        tick();
        upd_valid = 1'b0;
        lkp_valid = 1'b1;
        lkp_idx = 6'd12;
        tick();
        lkp_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, inv_busy, tag0_cs, tag1_cs} !== 4'b0100) begin
            errors++;
            $display("FAIL rst_drop: rv,busy,cs0,cs1=%b, required 0100",
                     {rsp_valid, inv_busy, tag0_cs, tag1_cs});
        end
        clear_ref();
        tick();
        rst = 1'b0;
        run_sweep("rst_sweep");
        lkp_valid = 1'b1;
        sbq.push_back({ref0[12], ref1[12]});
        tick();
        lkp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || sbq.size() == 0) begin
            errors++;
            $display("FAIL rst_rsp_valid: rsp_valid=%b, required 1", rsp_valid);
        end else begin
            exp_rsp = sbq.pop_front();
            checks++;
            if ({rsp_tag0, rsp_tag1} !== exp_rsp) begin
                errors++;
                $display("FAIL rst_cleared: tag0=%h tag1=%h, required %h %h",
                         rsp_tag0, rsp_tag1, exp_rsp[2*TW-1:TW], exp_rsp[TW-1:0]);
            end
        end
        tick();
    endtask

`ifdef N101_ICACHE_TRAM_PARITY_EN
    task automatic test_parity();
        upd_valid = 1'b1;
        upd_way = 1'b0;
        upd_idx = 6'd7;
        upd_tag = 22'h155555;
        tick();
        upd_valid = 1'b0;
        lkp_valid = 1'b1;
        lkp_idx = 6'd7;
        tick();
        lkp_valid = 1'b0;
        flip0 = TWR'(8);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || perr !== 1'b1 || rsp_tag0 !== (22'h155555 ^ 22'h8)) begin
            errors++;
            $display("FAIL par_err: rv=%b perr=%b tag0=%h, required 1 1 %h",
                     rsp_valid, perr, rsp_tag0, 22'h155555 ^ 22'h8);
        end
        tick();
        flip0 = '0;
        @(negedge clk);
        checks++;
        if (perr !== 1'b0) begin
            errors++;
            $display("FAIL par_pulse: perr=%b, required 0", perr);
        end
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        inv_req = 1'b0;
        lkp_valid = 1'b0;
        lkp_idx = '0;
        upd_valid = 1'b0;
        upd_way = 1'b0;
        upd_idx = '0;
        upd_tag = '0;
        flip0 = '0;
        rd0 = '0;
        rd1 = '0;
        for (int i = 0; i < DP; i++) begin
            mem0[i] = TWR'($urandom);
            mem1[i] = TWR'($urandom);
        end
        test_reset();
        test_sweep();
        test_upd_lookup();
        test_collision();
        test_back_to_back();
        test_inv_mid_sweep();
        test_rst_mid_lookup();
`ifdef N101_ICACHE_TRAM_PARITY_EN
        test_parity();
`endif
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
